// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and width limits for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - single-bit combinational full-adder cell
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] ss_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          ss_q    <= {fa_s, ss_q[WIDTH-1:1]};
          carry_q <= fa_co;
          // carry_q still holds the carry into the MSB here, so it feeds overflow
          if (last_bit) begin
            sum_q   <= {fa_s, ss_q[WIDTH-1:1]};
            c_out_q <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       v;
    int         acc;
  } exp8_t;

  typedef struct {
    logic [3:0] sum;
    logic       c;
    logic       v;
    int         acc;
  } exp4_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, c8, v8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, c4, v4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp8_t q8[$];
  exp4_t q4[$];
  exp8_t e8m;
  exp4_t e4m;
  logic [7:0] prev_sum8 = '0;
  logic       prev_rst = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c8), .ovf(v8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c4), .ovf(v4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp8_t model8(logic [7:0] a, logic [7:0] b, logic ci, int acc);
    exp8_t e;
    logic [8:0] t;
    t     = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    e.sum = t[7:0];
    e.c   = t[8];
    e.v   = (a[7] == b[7]) && (t[7] != a[7]);
    e.acc = acc;
    return e;
  endfunction

  function automatic exp4_t model4(logic [3:0] a, logic [3:0] b, logic ci, int acc);
    exp4_t e;
    logic [4:0] t;
    t     = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    e.sum = t[3:0];
    e.c   = t[4];
    e.v   = (a[3] == b[3]) && (t[3] != a[3]);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: done pulse with no outstanding request, sum=%h", sum8);
      end else begin
        e8m = q8.pop_front();
        if (sum8 !== e8m.sum || c8 !== e8m.c || v8 !== e8m.v || (cyc - e8m.acc) != 8) begin
          errors++;
          $display("FAIL result8: got sum=%h c=%b v=%b lat=%0d, want sum=%h c=%b v=%b lat=8",
                   sum8, c8, v8, cyc - e8m.acc, e8m.sum, e8m.c, e8m.v);
        end
      end
    end else if (rst_n && prev_rst) begin
      checks++;
      if (sum8 !== prev_sum8) begin
        errors++;
        $display("FAIL sum8_stable: sum changed to %h from %h without done", sum8, prev_sum8);
      end
    end
    prev_sum8 <= sum8;
    prev_rst  <= rst_n;
  end

  always @(negedge clk) begin
    if (done4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL done4_unexpected: done pulse with no outstanding request, sum=%h", sum4);
      end else begin
        e4m = q4.pop_front();
        if (sum4 !== e4m.sum || c4 !== e4m.c || v4 !== e4m.v || (cyc - e4m.acc) != 4) begin
          errors++;
          $display("FAIL result4: got sum=%h c=%b v=%b lat=%0d, want sum=%h c=%b v=%b lat=4",
                   sum4, c4, v4, cyc - e4m.acc, e4m.sum, e4m.c, e4m.v);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, c8, v8} !== 12'd0) begin
      errors++;
      $display("FAIL reset8_outputs: got %h, want 000", {busy8, done8, sum8, c8, v8});
    end
    checks++;
    if ({busy4, done4, sum4, c4, v4} !== 8'd0) begin
      errors++;
      $display("FAIL reset4_outputs: got %h, want 00", {busy4, done4, sum4, c4, v4});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done got %b, want 00", {busy8, done8});
    end
  endtask

  task automatic test_basic_add();
    int nb;
    int n;
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h5A, 8'h3C, 1'b0, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    nb = (busy8 === 1'b1) ? 1 : 0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
      if (busy8 === 1'b1) nb++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL basic_timeout: done never seen, got %b want 1", done8);
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", nb);
    end
    checks++;
    if (sum8 !== 8'h96 || c8 !== 1'b0 || v8 !== 1'b1) begin
      errors++;
      $display("FAIL basic_const: got sum=%h c=%b v=%b, want sum=96 c=0 v=1", sum8, c8, v8);
    end
    @(negedge clk);
  endtask

  task automatic test_carry();
    logic [7:0] av[3];
    logic [7:0] bv[3];
    logic       cv[3];
    int n;
    av = '{8'hFF, 8'h00, 8'h80};
    bv = '{8'h01, 8'h00, 8'h80};
    cv = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a8 = av[i]; b8 = bv[i]; cin8 = cv[i]; start8 = 1'b1;
      q8.push_back(model8(av[i], bv[i], cv[i], cyc + 1));
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (done8 !== 1'b1) begin
        errors++;
        $display("FAIL carry_timeout[%0d]: done got %b want 1", i, done8);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h10, 8'h20, 1'b0, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h30) begin
      errors++;
      $display("FAIL busy_ignore: got done=%b sum=%h, want done=1 sum=30", done8, sum8);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[4];
    logic [7:0] bv[4];
    int n;
    av = '{8'h12, 8'h7F, 8'hC3, 8'hA5};
    bv = '{8'h34, 8'h01, 8'h9E, 8'h5B};
    a8 = av[0]; b8 = bv[0]; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back(model8(av[0], bv[0], 1'b1, cyc + 1));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (done8 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_timeout[%0d]: done got %b want 1", i, done8);
      end
      if (i < 4) begin
        a8 = av[i]; b8 = bv[i]; cin8 = 1'b1;
        q8.push_back(model8(av[i], bv[i], 1'b1, cyc + 1));
      end else begin
        start8 = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int n;
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, c8, v8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_run: outputs got %h, want 000", {busy8, done8, sum8, c8, v8});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h01, 8'h01, 1'b0, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || sum8 !== 8'h02) begin
      errors++;
      $display("FAIL after_reset_add: got done=%b sum=%h, want done=1 sum=02", done8, sum8);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4();
    int n;
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
      q4.push_back(model4(v[3:0], v[7:4], v[8], cyc + 1));
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (done4 !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL exh4_timeout[%0d]: done got %b want 1", i, done4);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive4();
    checks++;
    if (q8.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: outstanding q8=%0d q4=%0d, want 0 0", q8.size(), q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
